// File: rtl/ysyx_22041207_idex_buf.sv
// ID->EX issue buffer: 2-entry skid buffer between decode and the ALU.
// The head entry drives out_*; a second (skid) entry absorbs one bundle when
// the ALU stalls. Both entries refresh rs1/rs2 from EX/WB results every cycle.
module ysyx_22041207_idex_buf #(
  parameter int XLEN = 64,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rs1_idx,
  input  logic [4:0]      in_rs2_idx,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_csr,
  input  logic [XLEN-1:0] in_imm,
  input  logic [OPW-1:0]  in_operate,
  input  logic [1:0]      in_sel_a,
  input  logic [1:0]      in_sel_b,
  input  logic            in_rs1to32,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_wen,
  input  logic            fwd_ex_valid,
  input  logic [4:0]      fwd_ex_rd,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_wb_valid,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_csr,
  output logic [XLEN-1:0] out_imm,
  output logic [OPW-1:0]  out_operate,
  output logic [1:0]      out_sel_a,
  output logic [1:0]      out_sel_b,
  output logic            out_rs1to32,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] csr;
    logic [XLEN-1:0] imm;
    logic [OPW-1:0]  operate;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;
    logic            rs1to32;
    logic [4:0]      rd;
    logic            rd_wen;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

  occ_e    state, state_n;
  bundle_t head, head_n, skid, skid_n, cap;
  logic    accept, issue;

  // Pick the freshest value for one operand; x0 is hardwired and never bypassed.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] idx, input logic [XLEN-1:0] v);
    if (idx == 5'd0)                          return v;
    if (fwd_ex_valid && fwd_ex_rd == idx)     return fwd_ex_data;
    if (fwd_wb_valid && fwd_wb_rd == idx)     return fwd_wb_data;
    return v;
  endfunction

  function automatic bundle_t fwd_b(input bundle_t b);
    bundle_t r;
    r     = b;
    r.rs1 = fwd(b.rs1_idx, b.rs1);
    r.rs2 = fwd(b.rs2_idx, b.rs2);
    return r;
  endfunction

  assign cap = '{pc: in_pc, rs1_idx: in_rs1_idx, rs2_idx: in_rs2_idx, rs1: in_rs1,
                 rs2: in_rs2, csr: in_csr, imm: in_imm, operate: in_operate,
                 sel_a: in_sel_a, sel_b: in_sel_b, rs1to32: in_rs1to32,
                 rd: in_rd, rd_wen: in_rd_wen};

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;

  // Occupancy transitions and entry movement; held entries refresh forwarded operands.
  always_comb begin
    state_n = state;
    head_n  = fwd_b(head);
    skid_n  = fwd_b(skid);
    case (state)
      EMPTY: if (accept) begin
        head_n  = fwd_b(cap);
        state_n = ONE;
      end
      ONE: begin
        if (accept && issue) head_n = fwd_b(cap);
        else if (accept) begin
          skid_n  = fwd_b(cap);
          state_n = TWO;
        end else if (issue) state_n = EMPTY;
      end
      TWO: if (issue) begin
        head_n  = fwd_b(skid);
        state_n = ONE;
      end
      default: state_n = EMPTY;
    endcase
    // Redirect wins: nothing in flight or arriving survives.
    if (flush) begin
      state_n = EMPTY;
      head_n  = head;
      skid_n  = skid;
    end
  end

  // State and entry registers; reset wipes everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_n;
      head  <= head_n;
      skid  <= skid_n;
    end
  end

  assign out_pc      = head.pc;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_csr     = head.csr;
  assign out_imm     = head.imm;
  assign out_operate = head.operate;
  assign out_sel_a   = head.sel_a;
  assign out_sel_b   = head.sel_b;
  assign out_rs1to32 = head.rs1to32;
  assign out_rd      = head.rd;
  assign out_rd_wen  = head.rd_wen;

endmodule

// File: tb/tb_ysyx_22041207_idex_buf.sv
// Directed bench for the ID->EX skid buffer: reset, streaming, backpressure,
// forwarding priority, flush and simultaneous accept/issue.
module tb_ysyx_22041207_idex_buf;
  localparam int XLEN = 64;
  localparam int OPW  = 5;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_rs1, in_rs2, in_csr, in_imm;
  logic [4:0]      in_rs1_idx, in_rs2_idx, in_rd;
  logic [OPW-1:0]  in_operate;
  logic [1:0]      in_sel_a, in_sel_b;
  logic            in_rs1to32, in_rd_wen;
  logic            fwd_ex_valid, fwd_wb_valid;
  logic [4:0]      fwd_ex_rd, fwd_wb_rd;
  logic [XLEN-1:0] fwd_ex_data, fwd_wb_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_rs1, out_rs2, out_csr, out_imm;
  logic [OPW-1:0]  out_operate;
  logic [1:0]      out_sel_a, out_sel_b;
  logic            out_rs1to32, out_rd_wen;
  logic [4:0]      out_rd;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22041207_idex_buf #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_csr(in_csr), .in_imm(in_imm), .in_operate(in_operate),
    .in_sel_a(in_sel_a), .in_sel_b(in_sel_b), .in_rs1to32(in_rs1to32),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_csr(out_csr), .out_imm(out_imm),
    .out_operate(out_operate), .out_sel_a(out_sel_a), .out_sel_b(out_sel_b),
    .out_rs1to32(out_rs1to32), .out_rd(out_rd), .out_rd_wen(out_rd_wen)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Offer a bundle; other payload fields are derived from pc so travel can be checked.
  task automatic offer(input logic v, input logic [63:0] pc, input logic [4:0] i1,
                       input logic [63:0] r1, input logic [4:0] i2, input logic [63:0] r2);
    in_valid   = v;
    in_pc      = pc;
    in_rs1_idx = i1;
    in_rs1     = r1;
    in_rs2_idx = i2;
    in_rs2     = r2;
    in_csr     = pc + 64'd2;
    in_imm     = pc + 64'd1;
    in_operate = pc[6:2];
    in_sel_a   = 2'd1;
    in_sel_b   = 2'd2;
    in_rs1to32 = pc[2];
    in_rd      = pc[6:2];
    in_rd_wen  = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_set(input logic ev, input logic [4:0] er, input logic [63:0] ed,
                         input logic wv, input logic [4:0] wr, input logic [63:0] wd);
    fwd_ex_valid = ev; fwd_ex_rd = er; fwd_ex_data = ed;
    fwd_wb_valid = wv; fwd_wb_rd = wr; fwd_wb_data = wd;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    offer(1'b0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0);
    fwd_set(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_pc",    out_pc,         64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Stream: four back-to-back bundles, one issued per cycle
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 64'h8000_0000 + 64'(4*i), 5'd0, 64'h0, 5'd0, 64'h0);
      step();
      chk($sformatf("stream_valid%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("stream_pc%0d", i), out_pc, 64'h8000_0000 + 64'(4*i));
    end
    chk("stream_imm", out_imm, 64'h8000_000d);
    chk("stream_csr", out_csr, 64'h8000_000e);
    chk("stream_op",  64'(out_operate), 64'd3);
    offer(1'b0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0);
    step();
    chk("stream_drain", 64'(out_valid), 64'd0);

    // Backpressure: A, B fill the buffer, C stalls
    out_ready = 1'b0;
    offer(1'b1, 64'h100, 5'd0, 64'h0, 5'd0, 64'h0);
    step();
    chk("bp_ready_one", 64'(in_ready), 64'd1);
    offer(1'b1, 64'h200, 5'd0, 64'h0, 5'd0, 64'h0);
    step();
    chk("bp_ready_two", 64'(in_ready), 64'd0);
    chk("bp_head_a", out_pc, 64'h100);
    offer(1'b1, 64'h300, 5'd0, 64'h0, 5'd0, 64'h0);
    step();
    chk("bp_stall", 64'(in_ready), 64'd0);
    chk("bp_hold_a", out_pc, 64'h100);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", out_pc, 64'h200);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    chk("bp_head_c", out_pc, 64'h300);
    offer(1'b0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Forwarding priority on a held entry
    out_ready = 1'b0;
    offer(1'b1, 64'h400, 5'd5, 64'hAA, 5'd0, 64'h0);
    step();
    chk("fwd_capture", out_rs1, 64'hAA);
    offer(1'b0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0);
    fwd_set(1'b1, 5'd5, 64'h11, 1'b1, 5'd5, 64'h22);
    step();
    chk("fwd_ex_wins", out_rs1, 64'h11);
    fwd_set(1'b0, 5'd5, 64'h11, 1'b1, 5'd5, 64'h22);
    step();
    chk("fwd_wb_only", out_rs1, 64'h22);
    chk("fwd_pc_stable", out_pc, 64'h400);

    // Simultaneous accept+issue in ONE; x0 not forwarded, rs2 forwarded at capture
    out_ready = 1'b1;
    offer(1'b1, 64'h500, 5'd0, 64'h55, 5'd7, 64'h66);
    fwd_set(1'b1, 5'd0, 64'h99, 1'b1, 5'd7, 64'h77);
    step();
    chk("sim_valid", 64'(out_valid), 64'd1);
    chk("sim_pc",    out_pc, 64'h500);
    chk("x0_capture", out_rs1, 64'h55);
    chk("fwd_cap_rs2", out_rs2, 64'h77);
    out_ready = 1'b0;
    offer(1'b0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0);
    step();
    chk("x0_held", out_rs1, 64'h55);
    fwd_set(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);

    // Flush in TWO with an arriving bundle
    offer(1'b1, 64'h600, 5'd0, 64'h0, 5'd0, 64'h0);
    step();
    chk("fl_two", 64'(in_ready), 64'd0);
    offer(1'b1, 64'h700, 5'd0, 64'h0, 5'd0, 64'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    offer(1'b0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0);
    step();
    chk("fl_dropped", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    offer(1'b1, 64'h800, 5'd0, 64'h0, 5'd0, 64'h0);
    step();
    chk("fl_next_pc", out_pc, 64'h800);

    // Asynchronous reset mid-stream with both entries full
    out_ready = 1'b0;
    offer(1'b1, 64'h900, 5'd3, 64'h33, 5'd0, 64'h0);
    step();
    chk("rst2_two", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_ready", 64'(in_ready), 64'd1);
    chk("rst2_pc",    out_pc, 64'd0);
    chk("rst2_imm",   out_imm, 64'd0);
    offer(1'b0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst2_after", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
